// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light controller: state codes, widths and sweep patterns.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tail_light_pkg;

    localparam int STATE_W = 3;
    localparam int LAMP_W  = 3;

    // Codes produced by the next-state logic; anything above TURN_RIGHT is illegal.
    localparam logic [STATE_W-1:0] IDLE       = 3'b000;
    localparam logic [STATE_W-1:0] HAZARDS    = 3'b001;
    localparam logic [STATE_W-1:0] TURN_LEFT  = 3'b010;
    localparam logic [STATE_W-1:0] TURN_RIGHT = 3'b011;

    // Turn sweep, inner lamp first, one pattern per phase.
    localparam logic [LAMP_W-1:0] SWEEP0 = 3'b000;
    localparam logic [LAMP_W-1:0] SWEEP1 = 3'b001;
    localparam logic [LAMP_W-1:0] SWEEP2 = 3'b011;
    localparam logic [LAMP_W-1:0] SWEEP3 = 3'b111;

    // Both lamp banks together, as driven by the decode.
    typedef struct packed {
        logic [LAMP_W-1:0] left;
        logic [LAMP_W-1:0] right;
    } lamps_t;

    // Map a 2-bit phase onto the turn sweep.
    function automatic logic [LAMP_W-1:0] sweep_pattern(input logic [1:0] phase);
        logic [LAMP_W-1:0] pat;
        case (phase)
            2'd0:    pat = SWEEP0;
            2'd1:    pat = SWEEP1;
            2'd2:    pat = SWEEP2;
            default: pat = SWEEP3;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/tail_light_sequencer_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles; clear restarts the count.
// Latency: first tick TICK_DIV cycles after reset/clear is released.
// Backpressure: none; a tick coinciding with clear or reset is suppressed.
module tick_prescaler #(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] presc;

    // Terminal count; clear wins so the owner never sees a tick on a restart edge.
    assign tick = (presc == LAST) && !clear && !reset;

    // Count up to TICK_DIV-1 and wrap; reset or clear return to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc <= '0;
        end else if (presc == LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tail_light_sequencer.sv
// Registers the tail-light state and drives the six lamps: hazard flash or inner-to-outer turn sweep.
// Latency: 1 cycle from state_in change to lamp change; each step lasts TICK_DIV cycles.
// Backpressure: none; any state change restarts the sequence immediately.
module tail_light_sequencer
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STATE_W-1:0] state_in,
    output logic [LAMP_W-1:0] lights_left,
    output logic [LAMP_W-1:0] lights_right,
    output logic              seq_wrap,
    output logic              fault
);

    logic [STATE_W-1:0] state_q;
    logic [1:0]         phase;
    logic               wrap_q;
    logic               state_change;
    logic               tick;
    logic [1:0]         phase_nxt;
    logic               wrap_nxt;
    lamps_t             lamps;

    assign state_change = (state_in != state_q);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state_change),
        .tick  (tick)
    );

    // Next phase and wrap flag for the current pattern, used only on a tick.
    always_comb begin
        phase_nxt = 2'd0;
        wrap_nxt  = 1'b0;
        case (state_q)
            HAZARDS: begin
                phase_nxt = (phase == 2'd1) ? 2'd0 : 2'd1;
                wrap_nxt  = (phase == 2'd1);
            end
            TURN_LEFT, TURN_RIGHT: begin
                phase_nxt = phase + 2'd1;
                wrap_nxt  = (phase == 2'd3);
            end
            default: begin
                phase_nxt = 2'd0;
                wrap_nxt  = 1'b0;
            end
        endcase
    end

    // State register and sequence position; a state change restarts and drops the coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase   <= 2'd0;
            wrap_q  <= 1'b0;
        end else if (state_change) begin
            state_q <= state_in;
            phase   <= 2'd0;
            wrap_q  <= 1'b0;
        end else if (tick) begin
            phase  <= phase_nxt;
            wrap_q <= wrap_nxt;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    // Lamp decode from registers only, so the lamp outputs cannot glitch.
    always_comb begin
        lamps.left  = '0;
        lamps.right = '0;
        fault       = 1'b0;
        case (state_q)
            IDLE: begin
                lamps.left  = '0;
                lamps.right = '0;
            end
            HAZARDS: begin
                lamps.left  = (phase == 2'd0) ? SWEEP3 : SWEEP0;
                lamps.right = (phase == 2'd0) ? SWEEP3 : SWEEP0;
            end
            TURN_LEFT: begin
                lamps.left = sweep_pattern(phase);
            end
            TURN_RIGHT: begin
                lamps.right = sweep_pattern(phase);
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

    assign lights_left  = lamps.left;
    assign lights_right = lamps.right;
    assign seq_wrap     = wrap_q;

endmodule
